unidade_busca: RTL and testbench
================================

// Module: unidade_busca
// PURPOSE
//  Instruction sequencer directly upstream of unidade_controle. Fetches 9-bit words from
//  synchronous instruction memory via a PC and latches the instruction for the control unit.
//  For mvi, it also fetches the immediate word and presents it on DIN.
//  Generates Run and Tstep, and waits for Done before fetching the next instruction.
// PARAMETERS
//  ADDR_W   5       memory address / PC width
//  MEM_LAT  1       read latency of instruction memory in cycles (1..3)
//  HALT_OP  3'b111  opcode that stops sequencing
// PORTS
//  Clock      in   1       single clock, all state on rising edge
//  Resetn     in   1       reset: synchronous, active-high (port name fixed by processor top level)
//  Start      in   1       begin execution from PC=0 (level, sampled in IDLE only)
//  Mem_addr   out  ADDR_W  instruction memory address
//  Mem_rd     out  1       read strobe, one cycle per word
//  Mem_data   in   9       read data, valid exactly MEM_LAT cycles after Mem_rd
//  Instrucao  out  9       latched instruction (IIIXXXYYY) to control unit
//  DIN        out  9       immediate word for mvi; otherwise equal to Instrucao
//  Run        out  1       high for the whole EXEC state
//  Tstep      out  2       00=T0..11=T3 to control unit
//  Done       in   1       instruction complete, from control unit
//  PC         out  ADDR_W  address of next word to fetch
//  Halted     out  1       HALT_OP executed
//  Erro       out  1       Done missing at T3
// BEHAVIOUR
//  Reset (Resetn=1 at edge): state=IDLE; PC, Mem_addr, Instrucao, DIN=0; Mem_rd, Run,
//   Halted, Erro=0; Tstep=00. Reset wins over every other event, including mid-fetch and
//   mid-EXEC. A memory word returned after reset is discarded.
//  States: IDLE, FETCH, WAIT_I, FETCH_IMM, WAIT_IMM, EXEC, HALT.
//  IDLE: Start=1 -> FETCH.
//  FETCH: Mem_addr<=PC, Mem_rd=1 for 1 cycle, PC<=PC+1 -> WAIT_I.
//  WAIT_I: counts MEM_LAT cycles. On the data cycle:
//   - Instrucao<=Mem_data, DIN<=Mem_data.
//   - opcode==HALT_OP -> HALT.
//   - opcode==3'b001 (mvi) -> FETCH_IMM.
//   - otherwise -> EXEC.
//  FETCH_IMM / WAIT_IMM: same timing as FETCH / WAIT_I, but DIN<=Mem_data and Instrucao is
//   held -> EXEC.
//  EXEC: Run=1; Tstep=00 on entry, +1 per cycle, saturates at 11.
//   - Done=1 -> Tstep<=00, Run<=0, next state FETCH (Run low for at least 1 cycle, so each
//     instruction gives a fresh Run rising edge).
//   - Tstep==11 and Done=0 -> Erro<=1 -> HALT.
//   - Done=1 at Tstep==11 is legal, no Erro.
//  HALT: Halted=1 (or Erro=1), Run=0; stays until reset. Start is ignored.
//  Start is ignored outside IDLE. Done is ignored outside EXEC.
//  PC wraps modulo 2^ADDR_W (31+1=0). An mvi at the last address takes its immediate from
//   address 0.
//  Latency: a non-mvi instruction reaches EXEC 2+MEM_LAT cycles after FETCH entry.
//   mvi adds 1+MEM_LAT cycles.
//  Outputs are registered except Run, which is decoded from state.
// STRUCTURE
//  proc_defs.vh (shared include):
//   - opcode constants OP_MV=000, OP_MVI=001, OP_ADD=010, OP_SUB=011, OP_HALT=111
//   - Tstep encodings T0..T3
//   - state encoding localparams for this block
//  Sub-module contador_tstep: 2-bit counter with Clear, Enable, saturate-at-11 and
//   synchronous active-high reset. It replaces the free-standing Tstep counter.
//  Main FSM, PC and latency counter live in this file.
// TESTING
//  1. Reset held 3 cycles mid-EXEC -> all outputs 0, state IDLE next cycle, no Mem_rd.
//  2. Mem[0]=9'o012 (mv R1,R2), Start=1, Done returned at T1 -> Instrucao=9'o012,
//     Run high 2 cycles, then Mem_rd with Mem_addr=1.
//  3. Mem[0]=9'o130 (mvi R3), Mem[1]=9'd5 -> two Mem_rd (addr 0, 1), DIN=5 in EXEC, PC=2.
//  4. Mem[0]=add, Done withheld -> Tstep 00,01,10,11, then Erro=1, HALT, Run=0.
//  5. Mem[31]=mvi, Mem[0]=9'd7, PC preset by running to 31 -> immediate read from addr 0,
//     DIN=7.
//  6. Mem[1]=9'o700 (halt) -> Halted=1 after 2nd fetch. Start pulses ignored;
//     MEM_LAT=3 rerun gives the same results with 2 extra wait cycles per word.

Source files
------------

// File: rtl/unidade_busca_pkg.sv
// Shared constants for the instruction sequencer: opcodes, Tstep codes and FSM state encoding.
package unidade_busca_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] T0 = 2'b00;
  localparam logic [1:0] T1 = 2'b01;
  localparam logic [1:0] T2 = 2'b10;
  localparam logic [1:0] T3 = 2'b11;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_I    = 3'd2;
  localparam logic [2:0] S_FETCH_IMM = 3'd3;
  localparam logic [2:0] S_WAIT_IMM  = 3'd4;
  localparam logic [2:0] S_EXEC      = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  function automatic logic [2:0] opcode_of(input logic [8:0] word);
    return word[8:6];
  endfunction

endpackage

// File: rtl/unidade_busca_contador_tstep.sv
// Two-bit Tstep counter: clear has priority over enable, and the count sticks at T3.
module contador_tstep
  import unidade_busca_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       clear,
  input  logic       enable,
  output logic [1:0] count
);

  logic [1:0] count_q;
  logic [1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = T0;
    end else if (enable && (count_q != T3)) begin
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= T0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction sequencer: fetches words through a PC, decodes mvi/halt, and paces the
// control unit with Run/Tstep until it answers with Done.
module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter int         ADDR_W  = 5,
  parameter int         MEM_LAT = 1,
  parameter logic [2:0] HALT_OP = OP_HALT
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic              Mem_rd,
  input  logic [8:0]        Mem_data,
  output logic [8:0]        Instrucao,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic [1:0]        Tstep,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic              Halted,
  output logic              Erro
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [8:0]        instr_q, instr_d;
  logic [8:0]        din_q, din_d;
  logic [1:0]        lat_q, lat_d;
  logic              halted_q, halted_d;
  logic              erro_q, erro_d;
  logic [1:0]        tstep_cnt;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    instr_d    = instr_q;
    din_d      = din_q;
    lat_d      = lat_q;
    halted_d   = halted_q;
    erro_d     = erro_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_addr_d = pc_q;
        mem_rd_d   = 1'b1;
        pc_d       = pc_q + 1'b1;
        lat_d      = 2'd0;
        state_d    = S_WAIT_I;
      end
      S_WAIT_I: begin
        if (lat_q == 2'(MEM_LAT)) begin
          instr_d = Mem_data;
          din_d   = Mem_data;
          if (opcode_of(Mem_data) == HALT_OP) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else if (opcode_of(Mem_data) == OP_MVI) begin
            // Immediate read is launched while the opcode is decoded, so it overlaps FETCH_IMM.
            mem_addr_d = pc_q;
            mem_rd_d   = 1'b1;
            pc_d       = pc_q + 1'b1;
            lat_d      = 2'd0;
            state_d    = S_FETCH_IMM;
          end else begin
            state_d = S_EXEC;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_FETCH_IMM: begin
        lat_d   = lat_q + 2'd1;
        state_d = S_WAIT_IMM;
      end
      S_WAIT_IMM: begin
        if (lat_q == 2'(MEM_LAT)) begin
          din_d   = Mem_data;
          state_d = S_EXEC;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_EXEC: begin
        if (Done) begin
          state_d = S_FETCH;
        end else if (tstep_cnt == T3) begin
          erro_d  = 1'b1;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      instr_q    <= '0;
      din_q      <= '0;
      lat_q      <= '0;
      halted_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      instr_q    <= instr_d;
      din_q      <= din_d;
      lat_q      <= lat_d;
      halted_q   <= halted_d;
      erro_q     <= erro_d;
    end
  end

  // Cleared whenever the next cycle is not EXEC, so every instruction starts at T0.
  contador_tstep u_tstep (
    .clk    (Clock),
    .srst   (Resetn),
    .clear  (state_d != S_EXEC),
    .enable (state_q == S_EXEC),
    .count  (tstep_cnt)
  );

  assign Run       = (state_q == S_EXEC);
  assign Tstep     = tstep_cnt;
  assign Mem_addr  = mem_addr_q;
  assign Mem_rd    = mem_rd_q;
  assign Instrucao = instr_q;
  assign DIN       = din_q;
  assign PC        = pc_q;
  assign Halted    = halted_q;
  assign Erro      = erro_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: two instances (read latency 1 and 3) run the same programs and are
// compared against an instruction-level model of the sequencer.
module tb_unidade_busca;
  import unidade_busca_pkg::*;

  localparam int AW   = 5;
  localparam int NI   = 2;
  localparam int MAXE = 48;
  localparam int MAXR = 2 * MAXE;

  logic Clock = 1'b0;
  logic Resetn;
  logic Start;
  always #5 Clock = ~Clock;

  logic [AW-1:0] mem_addr [NI];
  logic [AW-1:0] pc_o     [NI];
  logic          mem_rd   [NI];
  logic          run      [NI];
  logic          halted   [NI];
  logic          erro     [NI];
  logic          done_s   [NI];
  logic [8:0]    mem_data [NI];
  logic [8:0]    instr_o  [NI];
  logic [8:0]    din_o    [NI];
  logic [1:0]    tstep    [NI];

  logic [8:0] mem [32];
  logic [8:0] pipe_d [NI][3];
  logic       pipe_v [NI][3];
  logic [8:0] junk   [NI];
  int         plan   [MAXE];
  int         cyc = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    unidade_busca #(.ADDR_W(AW), .MEM_LAT(LAT), .HALT_OP(OP_HALT)) u_dut (
      .Clock(Clock), .Resetn(Resetn), .Start(Start),
      .Mem_addr(mem_addr[gi]), .Mem_rd(mem_rd[gi]), .Mem_data(mem_data[gi]),
      .Instrucao(instr_o[gi]), .DIN(din_o[gi]), .Run(run[gi]), .Tstep(tstep[gi]),
      .Done(done_s[gi]), .PC(pc_o[gi]), .Halted(halted[gi]), .Erro(erro[gi])
    );
    // Outside the valid cycle the memory bus carries random junk.
    assign mem_data[gi] = pipe_v[gi][LAT-1] ? pipe_d[gi][LAT-1] : junk[gi];
  end

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      pipe_v[i][0] <= mem_rd[i];
      pipe_d[i][0] <= mem[mem_addr[i]];
      for (int s = 1; s < 3; s++) begin
        pipe_v[i][s] <= pipe_v[i][s-1];
        pipe_d[i][s] <= pipe_d[i][s-1];
      end
      junk[i] <= 9'($urandom);
    end
  end

  // Observed behaviour per instance
  int act_instr [NI][MAXE];
  int act_din   [NI][MAXE];
  int act_pc    [NI][MAXE];
  int act_len   [NI][MAXE];
  int act_gap   [NI][MAXE];
  int act_addr  [NI][MAXR];
  int n_ev      [NI];
  int n_rd      [NI];
  int tstep_bad [NI];
  int anchor    [NI];
  int runlen    [NI];
  logic run_prev [NI];

  // Control-unit stand-in plus monitor: Done follows the plan in EXEC, random elsewhere.
  initial begin
    for (int i = 0; i < NI; i++) begin
      run_prev[i] = 1'b0; done_s[i] = 1'b0; n_ev[i] = 0; n_rd[i] = 0;
      tstep_bad[i] = 0; anchor[i] = 0; runlen[i] = 0;
    end
    forever begin
      @(negedge Clock);
      for (int i = 0; i < NI; i++) begin
        if (Resetn) begin
          run_prev[i] = 1'b0;
          done_s[i]   = 1'b0;
        end else begin
          if (mem_rd[i]) begin
            if (n_rd[i] < MAXR) act_addr[i][n_rd[i]] = int'(mem_addr[i]);
            n_rd[i]++;
          end
          if (run[i]) begin
            if (!run_prev[i]) begin
              runlen[i] = 0;
              if (n_ev[i] < MAXE) begin
                act_instr[i][n_ev[i]] = int'(instr_o[i]);
                act_din[i][n_ev[i]]   = int'(din_o[i]);
                act_pc[i][n_ev[i]]    = int'(pc_o[i]);
                act_gap[i][n_ev[i]]   = cyc - anchor[i];
              end
            end
            if (int'(tstep[i]) != ((runlen[i] > 3) ? 3 : runlen[i])) tstep_bad[i]++;
            runlen[i]++;
          end else if (run_prev[i]) begin
            if (n_ev[i] < MAXE) act_len[i][n_ev[i]] = runlen[i];
            n_ev[i]++;
            anchor[i] = cyc - 1;
          end
          run_prev[i] = run[i];
          if (run[i]) done_s[i] = (n_ev[i] < MAXE) && (int'(tstep[i]) == plan[n_ev[i]]);
          else        done_s[i] = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[lat%0d]: got %0d expected %0d", nm, lat_of(i), act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Instruction-level reference: walk memory from address 0 using the Done plan.
  int exp_n, exp_nrd, exp_pcf;
  logic exp_halt, exp_erro;
  int exp_instr [MAXE];
  int exp_din   [MAXE];
  int exp_pc    [MAXE];
  int exp_len   [MAXE];
  int exp_mvi   [MAXE];
  int exp_addr  [MAXR];

  task automatic build_model();
    logic [4:0] p;
    logic [8:0] w;
    p = '0; exp_n = 0; exp_nrd = 0; exp_halt = 1'b0; exp_erro = 1'b0;
    for (int k = 0; k < MAXE; k++) begin
      w = mem[p];
      exp_addr[exp_nrd] = int'(p); exp_nrd = exp_nrd + 1; p = p + 5'd1;
      if (w[8:6] == OP_HALT) begin exp_halt = 1'b1; break; end
      exp_instr[exp_n] = int'(w);
      exp_mvi[exp_n]   = (w[8:6] == OP_MVI) ? 1 : 0;
      if (w[8:6] == OP_MVI) begin
        exp_addr[exp_nrd] = int'(p); exp_nrd = exp_nrd + 1;
        exp_din[exp_n] = int'(mem[p]); p = p + 5'd1;
      end else begin
        exp_din[exp_n] = int'(w);
      end
      exp_pc[exp_n] = int'(p);
      if (plan[k] > 3) begin
        exp_len[exp_n] = 4; exp_erro = 1'b1; exp_n = exp_n + 1; break;
      end
      exp_len[exp_n] = plan[k] + 1;
      exp_n = exp_n + 1;
    end
    exp_pcf = int'(p);
  endtask

  task automatic start_prog(input int hold);
    Resetn = 1'b1; Start = 1'b0;
    tick(2);
    for (int i = 0; i < NI; i++) begin n_ev[i] = 0; n_rd[i] = 0; tstep_bad[i] = 0; end
    Resetn = 1'b0;
    tick(1);
    Start = 1'b1;
    for (int i = 0; i < NI; i++) anchor[i] = cyc;
    tick(hold);
    Start = 1'b0;
  endtask

  task automatic finish_prog();
    int w;
    int snap [NI];
    w = 0;
    while (!((halted[0] || erro[0]) && (halted[1] || erro[1])) && w < 5000) begin
      tick(1); w++;
    end
    chk("stop_timeout", 0, (w < 5000) ? 1 : 0, 1);
    for (int i = 0; i < NI; i++) snap[i] = n_rd[i];
    repeat (3) begin Start = 1'b1; tick(1); Start = 1'b0; tick(2); end
    tick(4);
    build_model();
    for (int i = 0; i < NI; i++) begin
      chk("start_in_halt_reads", i, n_rd[i], snap[i]);
      chk("run_in_halt", i, int'(run[i]), 0);
      chk("n_exec", i, n_ev[i], exp_n);
      for (int k = 0; k < exp_n && k < n_ev[i] && k < MAXE; k++) begin
        chk($sformatf("instr#%0d", k), i, act_instr[i][k], exp_instr[k]);
        chk($sformatf("din#%0d", k), i, act_din[i][k], exp_din[k]);
        chk($sformatf("pc#%0d", k), i, act_pc[i][k], exp_pc[k]);
        chk($sformatf("runlen#%0d", k), i, act_len[i][k], exp_len[k]);
        chk($sformatf("latency#%0d", k), i, act_gap[i][k],
            3 + lat_of(i) + ((exp_mvi[k] != 0) ? 1 + lat_of(i) : 0));
      end
      chk("n_reads", i, n_rd[i], exp_nrd);
      for (int k = 0; k < exp_nrd && k < n_rd[i] && k < MAXR; k++)
        chk($sformatf("rd_addr#%0d", k), i, act_addr[i][k], exp_addr[k]);
      chk("halted", i, int'(halted[i]), int'(exp_halt));
      chk("erro", i, int'(erro[i]), int'(exp_erro));
      chk("pc_final", i, int'(pc_o[i]), exp_pcf);
      chk("tstep_seq", i, tstep_bad[i], 0);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_mem_addr"}, i, int'(mem_addr[i]), 0);
      chk({tag, "_mem_rd"}, i, int'(mem_rd[i]), 0);
      chk({tag, "_instr"}, i, int'(instr_o[i]), 0);
      chk({tag, "_din"}, i, int'(din_o[i]), 0);
      chk({tag, "_run"}, i, int'(run[i]), 0);
      chk({tag, "_tstep"}, i, int'(tstep[i]), 0);
      chk({tag, "_pc"}, i, int'(pc_o[i]), 0);
      chk({tag, "_halted"}, i, int'(halted[i]), 0);
      chk({tag, "_erro"}, i, int'(erro[i]), 0);
    end
  endtask

  typedef struct {
    logic [8:0] w0, w1, w2;
    int         step0;
    int         n_ex;
    logic [8:0] e_instr, e_din;
    int         e_pc, e_len;
    logic       e_halt, e_erro;
    int         e_pcf;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int w, viol;
    Resetn = 1'b1; Start = 1'b0;
    vecs[0] = '{9'o012, 9'o700, 9'o700, 1, 1, 9'o012, 9'o012, 1, 2, 1'b1, 1'b0, 2};
    vecs[1] = '{9'o130, 9'd5,   9'o700, 0, 1, 9'o130, 9'd5,   2, 1, 1'b1, 1'b0, 3};
    vecs[2] = '{9'o234, 9'o700, 9'o700, 4, 1, 9'o234, 9'o234, 1, 4, 1'b0, 1'b1, 1};
    vecs[3] = '{9'o700, 9'o012, 9'o012, 0, 0, 9'o000, 9'o000, 0, 0, 1'b1, 1'b0, 1};
    vecs[4] = '{9'o101, 9'o777, 9'o700, 3, 1, 9'o101, 9'o777, 2, 4, 1'b1, 1'b0, 3};
    vecs[5] = '{9'o345, 9'o700, 9'o700, 2, 1, 9'o345, 9'o345, 1, 3, 1'b1, 1'b0, 2};

    for (int v = 0; v < 6; v++) begin
      for (int a = 0; a < 32; a++) mem[a] = 9'o700;
      mem[0] = vecs[v].w0; mem[1] = vecs[v].w1; mem[2] = vecs[v].w2;
      for (int k = 0; k < MAXE; k++) plan[k] = 0;
      plan[0] = vecs[v].step0; plan[MAXE-1] = 4;
      start_prog(4);
      finish_prog();
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("vec%0d_nexec", v), i, n_ev[i], vecs[v].n_ex);
        if (vecs[v].n_ex > 0 && n_ev[i] > 0) begin
          chk($sformatf("vec%0d_instr", v), i, act_instr[i][0], int'(vecs[v].e_instr));
          chk($sformatf("vec%0d_din", v), i, act_din[i][0], int'(vecs[v].e_din));
          chk($sformatf("vec%0d_pc", v), i, act_pc[i][0], vecs[v].e_pc);
          chk($sformatf("vec%0d_runlen", v), i, act_len[i][0], vecs[v].e_len);
        end
        chk($sformatf("vec%0d_halted", v), i, int'(halted[i]), int'(vecs[v].e_halt));
        chk($sformatf("vec%0d_erro", v), i, int'(erro[i]), int'(vecs[v].e_erro));
        chk($sformatf("vec%0d_pcf", v), i, int'(pc_o[i]), vecs[v].e_pcf);
      end
      $display("vector %0d: word0=%o done_step=%0d checked (total=%0d)", v, vecs[v].w0,
               vecs[v].step0, total);
    end

    // Reset held three cycles while EXEC is running
    for (int a = 0; a < 32; a++) mem[a] = 9'o234;
    for (int k = 0; k < MAXE; k++) plan[k] = 4;
    start_prog(4);
    w = 0;
    while (!run[1] && w < 30) begin tick(1); w++; end
    chk("reach_exec", 1, int'(run[1]), 1);
    Resetn = 1'b1;
    tick(1);
    chk_reset_state("rst1");
    tick(2);
    chk_reset_state("rst3");
    Resetn = 1'b0;
    viol = 0;
    repeat (6) begin
      tick(1);
      for (int i = 0; i < NI; i++) if (mem_rd[i] || run[i]) viol++;
    end
    chk("idle_after_reset", 0, viol, 0);
    $display("sequence reset_mid_exec checked (total=%0d)", total);

    // Reset while a read is outstanding: the late word must be dropped
    start_prog(1);
    w = 0;
    while (!mem_rd[1] && w < 30) begin tick(1); w++; end
    chk("saw_read", 1, int'(mem_rd[1]), 1);
    Resetn = 1'b1;
    tick(1);
    Resetn = 1'b0;
    viol = 0;
    repeat (6) begin
      tick(1);
      for (int i = 0; i < NI; i++) if (mem_rd[i]) viol++;
    end
    chk("no_read_after_reset", 0, viol, 0);
    for (int i = 0; i < NI; i++) begin
      chk("discard_instr", i, int'(instr_o[i]), 0);
      chk("discard_din", i, int'(din_o[i]), 0);
    end
    $display("sequence reset_discard checked (total=%0d)", total);

    // PC wrap: mvi at address 31 takes its immediate from address 0
    mem[0] = 9'd7;
    for (int a = 1; a < 31; a++) mem[a] = 9'o234;
    mem[31] = 9'o101;
    for (int k = 0; k < MAXE; k++) plan[k] = (k < 32) ? 0 : 4;
    start_prog(2);
    finish_prog();
    for (int i = 0; i < NI; i++) begin
      chk("wrap_din", i, act_din[i][31], 7);
      chk("wrap_pc", i, act_pc[i][31], 1);
      chk("wrap_imm_addr", i, act_addr[i][32], 0);
    end
    $display("sequence pc_wrap checked (total=%0d)", total);

    // Random programs
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 32; a++) begin
        int op;
        op = ($urandom_range(0, 24) == 0) ? 7 : int'($urandom_range(0, 6));
        mem[a] = {3'(op), 6'($urandom)};
      end
      for (int k = 0; k < MAXE; k++)
        plan[k] = ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(0, 3));
      plan[MAXE-1] = 4;
      start_prog(int'($urandom_range(1, 5)));
      finish_prog();
      $display("random program %0d: execs=%0d halted=%0d erro=%0d (total=%0d)", r, exp_n,
               exp_halt, exp_erro, total);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
